alu_arbiter: RTL and testbench

ALU_ARBITER -- requirements
Module: alu_arbiter

---
 rtl/alu_arbiter.sv | 141 ++++++++++++++
 tb/tb_alu_arbiter.sv | 277 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : alu_arbiter
//  Description : Two-requester round-robin front end for one shared,
//                registered ALU; one transaction in flight at a time.
//  Revision    : 1.0
// ============================================================================
module alu_arbiter #(
   parameter int LAT = 1
) (
   input  logic        clk,
   input  logic        rst,
   input  logic [1:0]  req_valid,
   output logic [1:0]  req_ready,
   input  logic [63:0] req_a,
   input  logic [63:0] req_b,
   input  logic [9:0]  req_shamt,
   input  logic [7:0]  req_funct,
   output logic [31:0] alu_a,
   output logic [31:0] alu_b,
   output logic [4:0]  alu_shamt,
   output logic [3:0]  alu_funct,
   input  logic [31:0] alu_out,
   output logic        rsp_valid,
   input  logic        rsp_ready,
   output logic        rsp_id,
   output logic [31:0] rsp_data,
   output logic        rsp_err
);

   localparam int            CW          = (LAT < 1) ? 1 : $clog2(LAT + 1);
   localparam logic [CW-1:0] c_cnt_last  = CW'(LAT);
   localparam logic [3:0]    c_funct_max = 4'd8;

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_EXEC = 2'd1,
      S_RESP = 2'd2
   } state_t;

   state_t        r_state;
   logic [CW-1:0] r_cnt;
   logic          r_last;
   logic [31:0]   r_alu_a;
   logic [31:0]   r_alu_b;
   logic [4:0]    r_alu_shamt;
   logic [3:0]    r_alu_funct;
   logic          r_rsp_id;
   logic [31:0]   r_rsp_data;
   logic          r_rsp_err;

   logic          w_gid;
   logic          w_accept;
   logic [31:0]   w_a;
   logic [31:0]   w_b;
   logic [4:0]    w_shamt;
   logic [3:0]    w_funct;

   // On a tie the requester that was not granted last wins.
   always_comb begin
      w_gid = 1'b0;
      case (req_valid)
         2'b01:   w_gid = 1'b0;
         2'b10:   w_gid = 1'b1;
         2'b11:   w_gid = ~r_last;
         default: w_gid = 1'b0;
      endcase
   end

   assign w_accept  = (r_state == S_IDLE) && (req_valid != 2'b00) && !rst;
   assign req_ready = w_accept ? (w_gid ? 2'b10 : 2'b01) : 2'b00;

   assign w_a     = w_gid ? req_a[63:32]    : req_a[31:0];
   assign w_b     = w_gid ? req_b[63:32]    : req_b[31:0];
   assign w_shamt = w_gid ? req_shamt[9:5]  : req_shamt[4:0];
   assign w_funct = w_gid ? req_funct[7:4]  : req_funct[3:0];

   assign alu_a     = r_alu_a;
   assign alu_b     = r_alu_b;
   assign alu_shamt = r_alu_shamt;
   assign alu_funct = r_alu_funct;

   assign rsp_valid = (r_state == S_RESP);
   assign rsp_id    = r_rsp_id;
   assign rsp_data  = r_rsp_data;
   assign rsp_err   = r_rsp_err;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state     <= S_IDLE;
         r_cnt       <= '0;
         r_last      <= 1'b1;
         r_alu_a     <= '0;
         r_alu_b     <= '0;
         r_alu_shamt <= '0;
         r_alu_funct <= '0;
         r_rsp_id    <= 1'b0;
         r_rsp_data  <= '0;
         r_rsp_err   <= 1'b0;
      end else begin
         case (r_state)
            S_IDLE: begin
               if (w_accept) begin
                  r_alu_a     <= w_a;
                  r_alu_b     <= w_b;
                  r_alu_shamt <= w_shamt;
                  r_alu_funct <= w_funct;
                  r_rsp_id    <= w_gid;
                  r_last      <= w_gid;
                  r_cnt       <= '0;
                  if (w_funct > c_funct_max) begin
                     // Illegal opcode skips the ALU entirely.
                     r_rsp_data <= '0;
                     r_rsp_err  <= 1'b1;
                     r_state    <= S_RESP;
                  end else begin
                     r_state    <= S_EXEC;
                  end
               end
            end
            S_EXEC: begin
               if (r_cnt == c_cnt_last) begin
                  r_rsp_data <= alu_out;
                  r_rsp_err  <= 1'b0;
                  r_state    <= S_RESP;
               end else begin
                  r_cnt <= r_cnt + 1'b1;
               end
            end
            S_RESP: begin
               if (rsp_ready) begin
                  r_state <= S_IDLE;
               end
            end
            default: r_state <= S_IDLE;
         endcase
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_alu_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : tb_alu_arbiter
//  Description : Self-checking bench for alu_arbiter with a one-stage ALU model.
//  Revision    : 1.0
// ============================================================================
module tb_alu_arbiter;

   localparam int LAT = 1;

   logic        clk = 1'b0;
   logic        rst;
   logic [1:0]  req_valid;
   logic [1:0]  req_ready;
   logic [63:0] req_a;
   logic [63:0] req_b;
   logic [9:0]  req_shamt;
   logic [7:0]  req_funct;
   logic [31:0] alu_a;
   logic [31:0] alu_b;
   logic [4:0]  alu_shamt;
   logic [3:0]  alu_funct;
   logic [31:0] alu_out;
   logic        rsp_valid;
   logic        rsp_ready;
   logic        rsp_id;
   logic [31:0] rsp_data;
   logic        rsp_err;

   int n_checks = 0;
   int n_err    = 0;

   typedef struct {
      logic        id;
      logic [3:0]  f;
      logic [31:0] a;
      logic [31:0] b;
      logic [4:0]  sh;
      logic [31:0] d;
      logic        err;
   } vec_t;

   typedef struct {
      logic        id;
      logic [31:0] d;
      logic        err;
      logic [31:0] a;
   } sb_t;

   sb_t  sbq[$];
   vec_t vecs[13];

   alu_arbiter #(.LAT(LAT)) dut (
      .clk       (clk),
      .rst       (rst),
      .req_valid (req_valid),
      .req_ready (req_ready),
      .req_a     (req_a),
      .req_b     (req_b),
      .req_shamt (req_shamt),
      .req_funct (req_funct),
      .alu_a     (alu_a),
      .alu_b     (alu_b),
      .alu_shamt (alu_shamt),
      .alu_funct (alu_funct),
      .alu_out   (alu_out),
      .rsp_valid (rsp_valid),
      .rsp_ready (rsp_ready),
      .rsp_id    (rsp_id),
      .rsp_data  (rsp_data),
      .rsp_err   (rsp_err)
   );

   always #5 clk = ~clk;

   // Shared ALU stand-in; illegal opcodes yield a marker that must never be captured.
   function automatic logic [31:0] alu_fn(input logic [31:0] a, input logic [31:0] b,
                                          input logic [4:0] sh, input logic [3:0] f);
      case (f)
         4'd0:    return a + b;
         4'd1:    return a - b;
         4'd2:    return a & b;
         4'd3:    return a | b;
         4'd4:    return a ^ b;
         4'd5:    return ~a;
         4'd6:    return a << sh;
         4'd7:    return $signed(a) >>> sh;
         4'd8:    return a >> sh;
         default: return 32'hDEAD_BEEF;
      endcase
   endfunction

   always_ff @(posedge clk) alu_out <= alu_fn(alu_a, alu_b, alu_shamt, alu_funct);

   function automatic vec_t mk_vec(input logic id, input logic [3:0] f, input logic [31:0] a,
                                   input logic [31:0] b, input logic [4:0] sh,
                                   input logic [31:0] d, input logic err);
      vec_t v;
      v.id = id; v.f = f; v.a = a; v.b = b; v.sh = sh; v.d = d; v.err = err;
      return v;
   endfunction

   function automatic sb_t mk_sb(input logic id, input logic [31:0] d, input logic err,
                                 input logic [31:0] a);
      sb_t s;
      s.id = id; s.d = d; s.err = err; s.a = a;
      return s;
   endfunction

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic drive(input logic id, input logic [3:0] f, input logic [31:0] a,
                        input logic [31:0] b, input logic [4:0] sh);
      if (id) begin
         req_a[63:32] = a; req_b[63:32] = b; req_shamt[9:5] = sh; req_funct[7:4] = f;
      end else begin
         req_a[31:0] = a; req_b[31:0] = b; req_shamt[4:0] = sh; req_funct[3:0] = f;
      end
      req_valid[id] = 1'b1;
   endtask

   // Returns just after the accept edge with the expected response queued.
   task automatic wait_grant(input logic [1:0] exp_ready, input sb_t item, input string name);
      int n = 0;
      #1;
      while (req_ready == 2'b00 && n < 20) begin
         @(negedge clk);
         #1;
         n++;
      end
      chk({name, " req_ready"}, {30'd0, req_ready}, {30'd0, exp_ready});
      sbq.push_back(item);
      @(posedge clk);
   endtask

   task automatic collect(input int exp_lat, input int hold, input string name);
      int  lat = 0;
      sb_t e;
      @(negedge clk);
      while (!rsp_valid && lat < 30) begin
         @(negedge clk);
         lat++;
      end
      chk({name, " latency"}, lat, exp_lat);
      chk({name, " req_ready in resp"}, {30'd0, req_ready}, 32'd0);
      if (sbq.size() == 0) begin
         chk({name, " scoreboard empty"}, 32'd0, 32'd1);
         e = mk_sb(1'b0, 32'd0, 1'b0, 32'd0);
      end else begin
         e = sbq.pop_front();
      end
      chk({name, " rsp_id"}, {31'd0, rsp_id}, {31'd0, e.id});
      chk({name, " rsp_data"}, rsp_data, e.d);
      chk({name, " rsp_err"}, {31'd0, rsp_err}, {31'd0, e.err});
      chk({name, " alu_a held"}, alu_a, e.a);
      for (int i = 0; i < hold; i++) begin
         @(negedge clk);
         chk({name, " hold rsp_valid"}, {31'd0, rsp_valid}, 32'd1);
         chk({name, " hold rsp_data"}, rsp_data, e.d);
         chk({name, " hold req_ready"}, {30'd0, req_ready}, 32'd0);
      end
      rsp_ready = 1'b1;
      @(negedge clk);
      chk({name, " rsp_valid after handshake"}, {31'd0, rsp_valid}, 32'd0);
      rsp_ready = 1'b0;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not complete");
      $fatal(1);
   end

   initial begin
      vecs[0]  = mk_vec(1'b0, 4'd0, 32'd12,        32'd3,         5'd0,  32'd15,        1'b0);
      vecs[1]  = mk_vec(1'b1, 4'd1, 32'd5,         32'd7,         5'd0,  32'hFFFF_FFFE, 1'b0);
      vecs[2]  = mk_vec(1'b0, 4'd2, 32'hF0F0_F0F0, 32'hFF00_FF00, 5'd0,  32'hF000_F000, 1'b0);
      vecs[3]  = mk_vec(1'b1, 4'd3, 32'h0F0F_0000, 32'h0000_00F0, 5'd0,  32'h0F0F_00F0, 1'b0);
      vecs[4]  = mk_vec(1'b0, 4'd4, 32'hAAAA_5555, 32'hFFFF_0000, 5'd0,  32'h5555_5555, 1'b0);
      vecs[5]  = mk_vec(1'b1, 4'd5, 32'h1234_5678, 32'd0,         5'd0,  32'hEDCB_A987, 1'b0);
      vecs[6]  = mk_vec(1'b0, 4'd6, 32'd3,         32'd0,         5'd31, 32'h8000_0000, 1'b0);
      vecs[7]  = mk_vec(1'b0, 4'd7, 32'hFFFF_FFF0, 32'd0,         5'd2,  32'hFFFF_FFFC, 1'b0);
      vecs[8]  = mk_vec(1'b1, 4'd8, 32'h8000_0000, 32'd0,         5'd31, 32'd1,         1'b0);
      vecs[9]  = mk_vec(1'b1, 4'd7, 32'h8000_0000, 32'd0,         5'd31, 32'hFFFF_FFFF, 1'b0);
      vecs[10] = mk_vec(1'b0, 4'd0, 32'hFFFF_FFFF, 32'd1,         5'd0,  32'd0,         1'b0);
      vecs[11] = mk_vec(1'b1, 4'd12, 32'd7,        32'd9,         5'd1,  32'd0,         1'b1);
      vecs[12] = mk_vec(1'b0, 4'd15, 32'd5,        32'd6,         5'd3,  32'd0,         1'b1);

      rst = 1'b1; req_valid = 2'b11; req_a = '0; req_b = '0;
      req_shamt = '0; req_funct = '0; rsp_ready = 1'b0;
      repeat (2) @(negedge clk);
      #1;
      chk("reset req_ready", {30'd0, req_ready}, 32'd0);
      chk("reset rsp_valid", {31'd0, rsp_valid}, 32'd0);
      chk("reset rsp_data", rsp_data, 32'd0);
      chk("reset rsp_id", {31'd0, rsp_id}, 32'd0);
      chk("reset rsp_err", {31'd0, rsp_err}, 32'd0);
      chk("reset alu_a", alu_a, 32'd0);
      chk("reset alu_funct", {28'd0, alu_funct}, 32'd0);
      req_valid = 2'b00;
      @(negedge clk);
      rst = 1'b0;

      // Tie after reset: req0 first, then req1, then req0 again.
      drive(1'b0, 4'd1, 32'd12, 32'd3, 5'd0);
      drive(1'b1, 4'd2, 32'd12, 32'd3, 5'd0);
      wait_grant(2'b01, mk_sb(1'b0, 32'd9, 1'b0, 32'd12), "tie0");
      #1 req_valid[0] = 1'b0;
      collect(LAT + 1, 0, "tie0");
      wait_grant(2'b10, mk_sb(1'b1, 32'd0, 1'b0, 32'd12), "tie1");
      #1 drive(1'b0, 4'd1, 32'd12, 32'd3, 5'd0);
      collect(LAT + 1, 0, "tie1");
      wait_grant(2'b01, mk_sb(1'b0, 32'd9, 1'b0, 32'd12), "tie2");
      #1 req_valid = 2'b00;
      collect(LAT + 1, 0, "tie2");

      for (int i = 0; i < 13; i++) begin
         string nm;
         nm = $sformatf("vec%0d", i);
         drive(vecs[i].id, vecs[i].f, vecs[i].a, vecs[i].b, vecs[i].sh);
         wait_grant(vecs[i].id ? 2'b10 : 2'b01,
                    mk_sb(vecs[i].id, vecs[i].d, vecs[i].err, vecs[i].a), nm);
         #1 req_valid = 2'b00;
         chk({nm, " alu_funct"}, {28'd0, alu_funct}, {28'd0, vecs[i].f});
         chk({nm, " alu_b"}, alu_b, vecs[i].b);
         chk({nm, " alu_shamt"}, {27'd0, alu_shamt}, {27'd0, vecs[i].sh});
         collect(vecs[i].err ? 0 : LAT + 1, 0, nm);
      end

      // Backpressure with a competing request pending throughout.
      drive(1'b0, 4'd0, 32'd100, 32'd23, 5'd0);
      wait_grant(2'b01, mk_sb(1'b0, 32'd123, 1'b0, 32'd100), "bp");
      #1 req_valid = 2'b00;
      drive(1'b1, 4'd4, 32'h0000_FFFF, 32'h0F0F_0F0F, 5'd0);
      collect(LAT + 1, 5, "bp");
      wait_grant(2'b10, mk_sb(1'b1, 32'h0F0F_F0F0, 1'b0, 32'h0000_FFFF), "bp_next");
      #1 req_valid = 2'b00;
      collect(LAT + 1, 0, "bp_next");

      // Reset during EXEC aborts the transaction and restores the pointer.
      drive(1'b0, 4'd0, 32'd1, 32'd2, 5'd0);
      wait_grant(2'b01, mk_sb(1'b0, 32'd3, 1'b0, 32'd1), "abort");
      #1 req_valid = 2'b00;
      @(negedge clk);
      rst = 1'b1;
      #1;
      chk("abort rsp_valid", {31'd0, rsp_valid}, 32'd0);
      chk("abort rsp_data", rsp_data, 32'd0);
      chk("abort rsp_id", {31'd0, rsp_id}, 32'd0);
      chk("abort alu_a", alu_a, 32'd0);
      chk("abort alu_b", alu_b, 32'd0);
      chk("abort req_ready", {30'd0, req_ready}, 32'd0);
      sbq.delete();
      @(negedge clk);
      rst = 1'b0;
      for (int i = 0; i < 4; i++) begin
         @(negedge clk);
         chk("no stale rsp_valid", {31'd0, rsp_valid}, 32'd0);
      end
      drive(1'b0, 4'd3, 32'hA0, 32'h05, 5'd0);
      drive(1'b1, 4'd0, 32'd1, 32'd1, 5'd0);
      wait_grant(2'b01, mk_sb(1'b0, 32'hA5, 1'b0, 32'hA0), "post_reset_tie");
      #1 req_valid = 2'b00;
      collect(LAT + 1, 0, "post_reset_tie");

      $display("Result: errors=%0d of %0d checks", n_err, n_checks);
      $finish;
   end

endmodule
`default_nettype wire
